// File: rtl/mac_serial_if.sv
// rtl/mac_serial_if.sv - operand/result handshake bundle for the serial lane MAC
interface mac_serial_if #(
  parameter int ATTR_WIDTH = 24,
  parameter int ACC_WIDTH  = 20
);

  // operand side
  logic                  in_valid;
  logic                  in_ready;
  logic [ATTR_WIDTH-1:0] inputattr;
  logic [ATTR_WIDTH-1:0] inputcoeff;

  // result side
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_WIDTH-1:0]  acc;
  logic                  overflow;

  // the block that issues operands and consumes results
  modport master (
    output in_valid,
    output inputattr,
    output inputcoeff,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  acc,
    input  overflow
  );

  // the MAC itself
  modport slave (
    input  in_valid,
    input  inputattr,
    input  inputcoeff,
    input  out_ready,
    output in_ready,
    output out_valid,
    output acc,
    output overflow
  );

endinterface

// File: rtl/mac_serial.sv
// rtl/mac_serial.sv - lane-serial unsigned dot product of two packed words
module mac_serial #(
  parameter int ATTR_WIDTH = 24,
  parameter int LANE_WIDTH = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int SATURATE   = 1
) (
  input logic        clk,
  input logic        rst,
  mac_serial_if.slave bus
);

  localparam int NUM_LANES  = ATTR_WIDTH / LANE_WIDTH;
  localparam int PROD_WIDTH = 2 * LANE_WIDTH;
  // enough headroom that the full sum of all lane products never wraps
  localparam int GROWTH     = PROD_WIDTH + $clog2(NUM_LANES + 1);
  localparam int SUM_WIDTH  = (GROWTH > ACC_WIDTH + 1) ? GROWTH : ACC_WIDTH + 1;
  localparam int IDX_WIDTH  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_LANE = IDX_WIDTH'(NUM_LANES - 1);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    HOLD
  } state_t;

  state_t                state;
  logic [ATTR_WIDTH-1:0] attr_q;
  logic [ATTR_WIDTH-1:0] coeff_q;
  logic [SUM_WIDTH-1:0]  sum_q;
  logic [IDX_WIDTH-1:0]  lane_q;

  logic                  in_ready_q;
  logic                  out_valid_q;
  logic                  overflow_q;
  logic [ACC_WIDTH-1:0]  acc_q;

  logic [ATTR_WIDTH-1:0] attr_shift;
  logic [ATTR_WIDTH-1:0] coeff_shift;
  logic [LANE_WIDTH-1:0] attr_lane;
  logic [LANE_WIDTH-1:0] coeff_lane;
  logic [PROD_WIDTH-1:0] product;
  logic [SUM_WIDTH-1:0]  sum_next;
  logic                  sum_over;
  logic [ACC_WIDTH-1:0]  result;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.acc       = acc_q;
  assign bus.overflow  = overflow_q;

  // current lane product, running sum and the value acc would take if this is the last lane
  always_comb begin
    attr_shift  = attr_q << (int'(lane_q) * LANE_WIDTH);
    coeff_shift = coeff_q << (int'(lane_q) * LANE_WIDTH);
    // lane 0 sits at the top of the word, so shifting left brings lane i to the top
    attr_lane   = attr_shift[ATTR_WIDTH-1 -: LANE_WIDTH];
    coeff_lane  = coeff_shift[ATTR_WIDTH-1 -: LANE_WIDTH];
    product     = PROD_WIDTH'(attr_lane) * PROD_WIDTH'(coeff_lane);
    sum_next    = sum_q + SUM_WIDTH'(product);
    sum_over    = |sum_next[SUM_WIDTH-1:ACC_WIDTH];
    if (sum_over && (SATURATE != 0)) begin
      result = '1;
    end else begin
      result = sum_next[ACC_WIDTH-1:0];
    end
  end

  // control FSM: accept in IDLE, one lane per cycle in MAC, present result in HOLD
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      attr_q      <= '0;
      coeff_q     <= '0;
      sum_q       <= '0;
      lane_q      <= '0;
      acc_q       <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            attr_q     <= bus.inputattr;
            coeff_q    <= bus.inputcoeff;
            sum_q      <= '0;
            lane_q     <= '0;
            in_ready_q <= 1'b0;
            state      <= MAC;
          end
        end
        MAC: begin
          sum_q  <= sum_next;
          lane_q <= lane_q + IDX_WIDTH'(1);
          if (lane_q == LAST_LANE) begin
            acc_q       <= result;
            overflow_q  <= sum_over;
            out_valid_q <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          // acc/overflow deliberately left alone so they persist until the next result
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_serial.sv
// tb/tb_mac_serial.sv - scoreboard bench for mac_serial at three parameter points
module tb_mac_serial;

  localparam int NUM_LANES = 3;
  localparam int NDUT      = 3;

  typedef struct {
    logic [31:0] acc;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [23:0] attr = '0;
  logic [23:0] coeff = '0;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  bit b2b = 1'b0;
  bit have_last = 1'b0;
  int last_acc = 0;

  exp_t exp_q [NDUT][$];
  int   acc_cyc_q [$];

  // dut0: defaults, dut1: 16-bit saturating, dut2: 16-bit wrapping
  mac_serial_if #(.ATTR_WIDTH(24), .ACC_WIDTH(20)) if0 ();
  mac_serial_if #(.ATTR_WIDTH(24), .ACC_WIDTH(16)) if1 ();
  mac_serial_if #(.ATTR_WIDTH(24), .ACC_WIDTH(16)) if2 ();

  assign if0.in_valid = in_valid;  assign if0.inputattr = attr;
  assign if0.inputcoeff = coeff;   assign if0.out_ready = out_ready;
  assign if1.in_valid = in_valid;  assign if1.inputattr = attr;
  assign if1.inputcoeff = coeff;   assign if1.out_ready = out_ready;
  assign if2.in_valid = in_valid;  assign if2.inputattr = attr;
  assign if2.inputcoeff = coeff;   assign if2.out_ready = out_ready;

  mac_serial #(.ATTR_WIDTH(24), .LANE_WIDTH(8), .ACC_WIDTH(20), .SATURATE(1))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  mac_serial #(.ATTR_WIDTH(24), .LANE_WIDTH(8), .ACC_WIDTH(16), .SATURATE(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  mac_serial #(.ATTR_WIDTH(24), .LANE_WIDTH(8), .ACC_WIDTH(16), .SATURATE(0))
    dut2 (.clk(clk), .rst(rst), .bus(if2));

  logic        o_valid [NDUT];
  logic        o_rdy   [NDUT];
  logic        o_ovf   [NDUT];
  logic [31:0] o_acc   [NDUT];

  always_comb begin
    o_valid[0] = if0.out_valid; o_rdy[0] = if0.in_ready; o_ovf[0] = if0.overflow; o_acc[0] = 32'(if0.acc);
    o_valid[1] = if1.out_valid; o_rdy[1] = if1.in_ready; o_ovf[1] = if1.overflow; o_acc[1] = 32'(if1.acc);
    o_valid[2] = if2.out_valid; o_rdy[2] = if2.in_ready; o_ovf[2] = if2.overflow; o_acc[2] = 32'(if2.acc);
  end

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int accw(input int d);
    return (d == 0) ? 20 : 16;
  endfunction

  function automatic bit sat(input int d);
    return d != 2;
  endfunction

  // reference: sum of per-byte products, then clamp or wrap against 2^accw
  function automatic exp_t model(input logic [23:0] a, input logic [23:0] c,
                                 input int w, input bit s);
    exp_t   e;
    longint total;
    longint limit;
    longint la;
    longint lc;
    total = 0;
    for (int k = 0; k < NUM_LANES; k++) begin
      la = longint'((a >> (8 * (NUM_LANES - 1 - k))) & 24'hFF);
      lc = longint'((c >> (8 * (NUM_LANES - 1 - k))) & 24'hFF);
      total += la * lc;
    end
    limit = longint'(1) << w;
    e.ovf = (total >= limit);
    if (!e.ovf)   e.acc = 32'(total);
    else if (s)   e.acc = 32'(limit - 1);
    else          e.acc = 32'(total % limit);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // push expected results at each acceptance; drop them if reset aborts the operation
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < NDUT; d++) exp_q[d].delete();
      acc_cyc_q.delete();
      have_last = 1'b0;
    end else if (in_valid && if0.in_ready) begin
      for (int d = 0; d < NDUT; d++) exp_q[d].push_back(model(attr, coeff, accw(d), sat(d)));
      acc_cyc_q.push_back(cyc);
      if (b2b && have_last) check("issue_interval", 32'(cyc - last_acc), 32'(NUM_LANES + 2));
      have_last = 1'b1;
      last_acc  = cyc;
    end
  end

  bit          prev_rst = 1'b1;
  logic        p_valid [NDUT];
  logic [31:0] p_acc   [NDUT];
  logic        p_ovf   [NDUT];

  // monitor: reset values, HOLD stability, latency, and result comparison on handshake
  always @(negedge clk) begin
    if (rst) begin
      prev_rst = 1'b1;
      for (int d = 0; d < NDUT; d++) p_valid[d] = 1'b0;
    end else begin
      for (int d = 0; d < NDUT; d++) begin
        if (prev_rst) begin
          check("reset_out_valid", 32'(o_valid[d]), 32'd0);
          check("reset_acc", o_acc[d], 32'd0);
          check("reset_overflow", 32'(o_ovf[d]), 32'd0);
          check("reset_in_ready", 32'(o_rdy[d]), 32'd1);
        end
        if (o_valid[d]) begin
          check("in_ready_during_hold", 32'(o_rdy[d]), 32'd0);
          if (p_valid[d]) begin
            check("hold_acc_stable", o_acc[d], p_acc[d]);
            check("hold_overflow_stable", 32'(o_ovf[d]), 32'(p_ovf[d]));
          end else if (exp_q[d].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_result: dut%0d presented acc 0x%0h with nothing outstanding", d, o_acc[d]);
          end else if (d == 0) begin
            check("latency", 32'(cyc - acc_cyc_q[0]), 32'(NUM_LANES + 1));
          end
          if (out_ready && exp_q[d].size() > 0) begin
            exp_t e;
            e = exp_q[d].pop_front();
            check($sformatf("acc_dut%0d", d), o_acc[d], e.acc);
            check($sformatf("overflow_dut%0d", d), 32'(o_ovf[d]), 32'(e.ovf));
            if (d == 0) void'(acc_cyc_q.pop_front());
          end
        end
        p_valid[d] = o_valid[d];
        p_acc[d]   = o_acc[d];
        p_ovf[d]   = o_ovf[d];
      end
      prev_rst = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [23:0] a, input logic [23:0] c);
    int t;
    t = 0;
    while (!if0.in_ready && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) timeout("wait_in_ready");
    attr     = a;
    coeff    = c;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    // scramble operands so any late sampling shows up as a wrong result
    attr     = 24'($urandom);
    coeff    = 24'($urandom);
  endtask

  task automatic drain(input bit rand_ready);
    int t;
    t = 0;
    while ((exp_q[0].size() != 0 || if0.out_valid) && t < 100) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      attr      = 24'($urandom);
      coeff     = 24'($urandom);
      tick();
      t++;
    end
    if (t >= 100) timeout("drain");
    out_ready = 1'b1;
  endtask

  function automatic logic [23:0] rand_word();
    logic [23:0] w;
    int r;
    w = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      r = $urandom_range(0, 3);
      w = w << 8;
      if (r == 0)      w[7:0] = 8'hFF;
      else if (r == 1) w[7:0] = 8'h00;
      else             w[7:0] = 8'($urandom);
    end
    return w;
  endfunction

  initial begin
    int t;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // basic values, including all-ones lanes that overflow the 16-bit variants
    issue(24'h010203, 24'h040506);
    drain(1'b0);
    issue(24'hFFFFFF, 24'hFFFFFF);
    drain(1'b0);

    // result held while downstream stalls; in_valid ignored
    out_ready = 1'b0;
    issue(24'h010203, 24'h040506);
    t = 0;
    while (!if0.out_valid && t < 20) begin tick(); t++; end
    if (t >= 20) timeout("wait_out_valid");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      attr     = 24'($urandom);
      coeff    = 24'($urandom);
      tick();
      check("stall_in_ready", 32'(if0.in_ready), 32'd0);
      check("stall_out_valid", 32'(if0.out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("release_in_ready", 32'(if0.in_ready), 32'd1);
    check("release_out_valid", 32'(if0.out_valid), 32'd0);

    // reset in the second MAC cycle aborts the operation
    issue(24'h010203, 24'h040506);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_acc", 32'(if0.acc), 32'd0);
    check("abort_out_valid", 32'(if0.out_valid), 32'd0);
    check("abort_in_ready", 32'(if0.in_ready), 32'd1);
    repeat (8) tick();
    issue(24'h000001, 24'h000007);
    drain(1'b0);

    // back-to-back with in_valid held high; operands change mid-operation
    have_last = 1'b0;
    b2b       = 1'b1;
    attr      = 24'h010203;
    coeff     = 24'h040506;
    in_valid  = 1'b1;
    tick();
    attr  = 24'hFFFFFF;
    coeff = 24'hFFFFFF;
    t = 0;
    while (!if0.in_ready && t < 20) begin tick(); t++; end
    if (t >= 20) timeout("b2b_in_ready");
    tick();
    in_valid = 1'b0;
    b2b      = 1'b0;
    drain(1'b0);

    // randomized operations with random backpressure and occasional aborts
    for (int n = 0; n < 60; n++) begin
      issue(rand_word(), rand_word());
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(0, 5)) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      drain(1'b1);
    end

    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/mac_serial.md
MAC_SERIAL -- requirements
Module: mac_serial

Interface
REQ-001 SHALL have parameter ATTR_WIDTH, default 24: width of the attribute and coefficient words.
REQ-002 SHALL have parameter LANE_WIDTH, default 8: width of one multiply lane; ATTR_WIDTH SHALL be an integer multiple of it.
REQ-003 SHALL have parameter ACC_WIDTH, default 20: width of the result output.
REQ-004 SHALL have parameter SATURATE, default 1: 1 = clamp result on overflow; 0 = wrap modulo 2^ACC_WIDTH.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1 bit: an operand pair is present.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts an operand pair.
REQ-009 SHALL have port inputattr, input, ATTR_WIDTH bits: the attribute word.
REQ-010 SHALL have port inputcoeff, input, ATTR_WIDTH bits: the coefficient word.
REQ-011 SHALL have port out_valid, output, 1 bit: acc holds a completed result.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream block takes the result.
REQ-013 SHALL have port acc, output, ACC_WIDTH bits: the dot-product result.
REQ-014 SHALL have port overflow, output, 1 bit: the current result exceeded ACC_WIDTH.

Function
REQ-015 SHALL define NUM_LANES = ATTR_WIDTH/LANE_WIDTH; lane 0 is the most-significant LANE_WIDTH slice of each word, and lanes proceed toward the LSB.
REQ-016 SHALL implement the FSM states IDLE, MAC and HOLD.
REQ-017 IDLE: in_ready=1, out_valid=0; when in_valid=1, SHALL register both words, clear the internal sum and lane index, and go to MAC.
REQ-018 MAC: in_ready=0; each cycle SHALL add the unsigned product attr_lane[i]*coeff_lane[i] (2*LANE_WIDTH bits) to the internal sum, then increment i.
REQ-019 Internal sum SHALL be at least ACC_WIDTH+1 bits wide, and any carry beyond ACC_WIDTH bits SHALL be recorded; no intermediate value SHALL be lost.
REQ-020 On the edge that adds lane NUM_LANES-1, SHALL load acc, set overflow, assert out_valid and go to HOLD.
  - Latency: out_valid is visible after exactly NUM_LANES edges following the acceptance edge.
REQ-021 overflow SHALL be 1 iff the true sum >= 2^ACC_WIDTH.
  - SATURATE=1: acc = 2^ACC_WIDTH-1.
  - SATURATE=0: acc = true sum mod 2^ACC_WIDTH.
REQ-022 HOLD: in_ready=0; acc, overflow and out_valid SHALL stay stable until out_ready=1.
  - When out_ready=1, SHALL clear out_valid and go to IDLE.
  - acc and overflow SHALL keep their value until the next result loads.
REQ-023 in_valid SHALL be ignored whenever in_ready=0; operand inputs SHALL be sampled only on the acceptance edge.
REQ-024 Minimum issue interval SHALL be NUM_LANES+2 cycles per operation.
REQ-025 A change of inputattr or inputcoeff during MAC or HOLD SHALL NOT affect the result.

Reset
REQ-026 While rst=1 at a rising edge, SHALL go to IDLE with acc=0, overflow=0, out_valid=0, internal sum=0 and lane index=0; in_ready=1 on the following cycle.
REQ-027 Reset asserted in MAC or HOLD SHALL abort the operation; no result for that operation SHALL ever be presented.
REQ-028 rst SHALL take priority over in_valid and out_ready in the same cycle.

Verification
REQ-029 Defaults; attr=0x010203, coeff=0x040506, out_ready=1 -> out_valid high 3 edges after acceptance; acc=0x00020 (32); overflow=0.
REQ-030 Defaults; attr=coeff=0xFFFFFF -> acc=0x2FA03 (195075); overflow=0.
REQ-031 ACC_WIDTH=16, attr=coeff=0xFFFFFF:
  - SATURATE=1 -> acc=0xFFFF, overflow=1.
  - SATURATE=0 -> acc=0xFA03, overflow=1.
REQ-032 Hold out_ready=0 for 5 cycles after a result -> acc, out_valid and overflow stable; in_ready=0; in_valid pulses ignored.
  - Then out_ready=1 for 1 cycle -> IDLE, in_ready=1.
REQ-033 Assert rst on the 2nd MAC cycle of attr=0x010203 -> acc=0, out_valid=0, in_ready=1.
  - A next operation with attr=0x000001, coeff=0x000007 -> acc=7.
REQ-034 Back-to-back operations with out_ready=1 and in_valid held high -> results 32 then 0x2FA03, accepted NUM_LANES+2 cycles apart.
